// File: rtl/io_frame_controller.sv
// io_frame_controller: host-side frame mover for the segmented data memory.
// Loads one frame of pixels into the input segment, raises start_io, waits
// for the processor's done pulse, then streams the output segment to the sink.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no frame in progress; first in_valid opens a new frame
// S_LOAD  | accepting input pixels, writing them to the input segment
// S_START | start_io just raised; processor cannot have answered yet
// S_WAIT  | start_io held, waiting for the processor's done pulse
// S_DRAIN | reading the output segment and streaming it to the sink

module io_frame_controller #(
  parameter int ADDR_WIDTH = 24,
  parameter int PIXEL      = 8,
  parameter int NUM_PIXELS = 90000,
  parameter int IN_BASE    = 302,
  parameter int OUT_BASE   = 90302
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PIXEL-1:0]      in_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [PIXEL-1:0]      mem_wd,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic                  mem_re,
  input  logic [PIXEL-1:0]      mem_rd,
  output logic                  start_io,
  input  logic                  cpu_done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PIXEL-1:0]      out_data,
  output logic                  busy
);

  localparam int CW = $clog2(NUM_PIXELS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NUM_PIXELS - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(NUM_PIXELS);
  localparam logic [ADDR_WIDTH-1:0] IN_BASE_A  = ADDR_WIDTH'(IN_BASE);
  localparam logic [ADDR_WIDTH-1:0] OUT_BASE_A = ADDR_WIDTH'(OUT_BASE);

  // The two segments must not overlap, or loading would corrupt results.
  if (IN_BASE + NUM_PIXELS - 1 >= OUT_BASE) begin : g_seg_overlap
    $error("io_frame_controller: input segment overlaps output segment");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic [CW-1:0]   rcnt_q, rcnt_d;
  logic [CW-1:0]   ocnt_q, ocnt_d;
  logic            in_ready_q, in_ready_d;
  logic            start_io_q, start_io_d;
  logic            inflight_q, inflight_d;
  logic [1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [PIXEL-1:0] fifo0_q, fifo0_d;
  logic [PIXEL-1:0] fifo1_q, fifo1_d;

  logic            wr_fire;
  logic            out_fire;
  logic            rd_fire;
  logic [1:0]      occ;

  assign in_ready  = in_ready_q;
  assign start_io  = start_io_q;
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (fifo_cnt_q != 2'd0);
  assign out_data  = fifo0_q;
  assign mem_we    = wr_fire;
  assign mem_wd    = wr_fire ? in_data : '0;
  assign mem_waddr = IN_BASE_A + ADDR_WIDTH'(wcnt_q);
  assign mem_raddr = OUT_BASE_A + ADDR_WIDTH'(rcnt_q);
  assign mem_re    = rd_fire;

  // Handshake strobes; a read is issued only if the skid buffer will still
  // have room once this cycle's pop (if any) is taken into account, which is
  // what lets the drain sustain one pixel per cycle.
  always_comb begin
    wr_fire  = (state_q == S_LOAD) && in_ready_q && in_valid;
    out_fire = out_valid && out_ready;
    occ      = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, out_fire};
    rd_fire  = (state_q == S_DRAIN) && (occ < 2'd2) && (rcnt_q < CNT_FULL);
  end

  // Frame sequencing: next state, counters and registered control outputs.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    rcnt_d     = rcnt_q;
    ocnt_d     = ocnt_q;
    in_ready_d = in_ready_q;
    start_io_d = start_io_q;
    inflight_d = rd_fire;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d    = S_LOAD;
          in_ready_d = 1'b1;
          wcnt_d     = '0;
        end
      end
      S_LOAD: begin
        if (wr_fire) begin
          if (wcnt_q == CNT_LAST) begin
            state_d    = S_START;
            in_ready_d = 1'b0;
            start_io_d = 1'b1;
            wcnt_d     = '0;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cpu_done) begin
          state_d    = S_DRAIN;
          start_io_d = 1'b0;
          rcnt_d     = '0;
          ocnt_d     = '0;
        end
      end
      S_DRAIN: begin
        if (rd_fire) begin
          rcnt_d = rcnt_q + 1'b1;
        end
        if (out_fire) begin
          if (ocnt_q == CNT_LAST) begin
            state_d = S_IDLE;
            ocnt_d  = '0;
            rcnt_d  = '0;
          end else begin
            ocnt_d = ocnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Two-entry skid buffer: fifo0 is the head and drives out_data directly.
  always_comb begin
    fifo0_d    = fifo0_q;
    fifo1_d    = fifo1_q;
    fifo_cnt_d = fifo_cnt_q;
    case ({inflight_q, out_fire})
      2'b10: begin
        if (fifo_cnt_q == 2'd0) begin
          fifo0_d = mem_rd;
        end else begin
          fifo1_d = mem_rd;
        end
        fifo_cnt_d = fifo_cnt_q + 2'd1;
      end
      2'b01: begin
        fifo0_d    = fifo1_q;
        fifo_cnt_d = fifo_cnt_q - 2'd1;
      end
      2'b11: begin
        if (fifo_cnt_q == 2'd1) begin
          fifo0_d = mem_rd;
        end else begin
          fifo0_d = fifo1_q;
          fifo1_d = mem_rd;
        end
      end
      default: begin
      end
    endcase
  end

  // State register; reset abandons any frame and drops start_io at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      ocnt_q     <= '0;
      in_ready_q <= 1'b0;
      start_io_q <= 1'b0;
      inflight_q <= 1'b0;
      fifo_cnt_q <= 2'd0;
      fifo0_q    <= '0;
      fifo1_q    <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      ocnt_q     <= ocnt_d;
      in_ready_q <= in_ready_d;
      start_io_q <= start_io_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      fifo0_q    <= fifo0_d;
      fifo1_q    <= fifo1_d;
    end
  end

endmodule
